// File: rtl/battle_pkg.sv
// battle_pkg: shared types and constants for the battle sequencer.
//   battle_state_e : 4-bit state encoding, also driven out on battle_state
//                    to the battle-screen text/sprite mux
//   KEY_*          : USB HID keycodes the sequencer reacts to
//   max3           : constant helper used to size the shared state timer
package battle_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_DECIDE      = 4'd1,
    ST_MOVE_SEL    = 4'd2,
    ST_USER_ATTACK = 4'd3,
    ST_USER_HOLD   = 4'd4,
    ST_WILD_ATTACK = 4'd5,
    ST_WILD_HOLD   = 4'd6,
    ST_USER_FAINT  = 4'd7,
    ST_WILD_FAINT  = 4'd8,
    ST_ESCAPE      = 4'd9,
    ST_END         = 4'd10
  } battle_state_e;

  localparam logic [7:0] KEY_F    = 8'h09;  // "fight" menu entry
  localparam logic [7:0] KEY_E    = 8'h08;  // escape attempt
  localparam logic [7:0] KEY_1    = 8'h1E;  // move '1'; move i is KEY_1 + i
  localparam logic [7:0] KEY_BKSP = 8'h2A;  // leave move selection

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: turns the level keycode from the keyboard path into a
// single-frame "new key" strobe so a held key acts only once.
//   frameClk   in  : frame clock
//   Reset      in  : synchronous, active-high
//   keycode    in  : current USB HID keycode, 8'h00 = no key
//   key_new    out : keycode is non-zero and differs from last frame's keycode
//   key_code_q out : keycode registered from the previous frame
module key_edge_detect (
  input  logic       frameClk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       key_new,
  output logic [7:0] key_code_q
);

  // Previous-frame keycode, captured every frame regardless of FSM state.
  always_ff @(posedge frameClk) begin
    if (Reset) begin
      key_code_q <= 8'h00;
    end else begin
      key_code_q <= keycode;
    end
  end

  assign key_new = (keycode != 8'h00) && (keycode != key_code_q);

endmodule

// File: rtl/battle_sequencer.sv
// battle_sequencer: turn-based battle controller between the keyboard keycode
// path and the HP/damage datapath.
//   frameClk     in  : frame clock, state advances once per frame
//   Reset        in  : synchronous, active-high
//   keycode      in  : USB HID keycode (8'h00 = none)
//   fight_on     in  : start request, looked at only in IDLE
//   abort        in  : forces END from any state other than IDLE/END
//   user_faint   in  : user creature HP == 0
//   wild_faint   in  : wild creature HP == 0
//   user_hit     out : one-frame pulse, apply user move damage to wild
//   wild_hit     out : one-frame pulse, apply wild damage to user
//   move_sel     out : chosen move index 0..NUM_MOVES-1
//   battle_end   out : one-frame pulse on battle completion
//   busy         out : high in every state except IDLE
//   turn_count   out : completed turns this battle, saturating at 255
//   battle_state out : current state encoding
// All outputs are registered from the next-state value, so they line up
// exactly with the state register.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int HOLD_LEN  = 128,
  parameter int FAINT_LEN = 256,
  parameter int ESC_LEN   = 64,
  parameter int NUM_MOVES = 4,
  parameter bit ESCAPE_EN = 1'b1
) (
  input  logic                           frameClk,
  input  logic                           Reset,
  input  logic [7:0]                     keycode,
  input  logic                           fight_on,
  input  logic                           abort,
  input  logic                           user_faint,
  input  logic                           wild_faint,
  output logic                           user_hit,
  output logic                           wild_hit,
  output logic [$clog2(NUM_MOVES+1)-1:0] move_sel,
  output logic                           battle_end,
  output logic                           busy,
  output logic [7:0]                     turn_count,
  output logic [3:0]                     battle_state
);

  localparam int MW      = $clog2(NUM_MOVES + 1);
  localparam int MAX_LEN = max3(HOLD_LEN, FAINT_LEN, ESC_LEN);
  localparam int TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_LEN - 1);
  localparam logic [TW-1:0] FAINT_LAST = TW'(FAINT_LEN - 1);
  localparam logic [TW-1:0] ESC_LAST   = TW'(ESC_LEN - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  // First keycode past the last valid move key.
  localparam logic [7:0]    KEY_MOVE_END = 8'(int'(KEY_1) + NUM_MOVES);

  battle_state_e state_r;
  battle_state_e state_fsm_s;
  battle_state_e state_next_s;
  logic [TW-1:0] timer_r;
  logic          key_new_s;
  logic [7:0]    key_prev_s;
  logic          move_key_s;
  logic [7:0]    key_off_s;
  logic          abort_ok_s;
  logic          unused_s;

  key_edge_detect u_key_edge (
    .frameClk   (frameClk),
    .Reset      (Reset),
    .keycode    (keycode),
    .key_new    (key_new_s),
    .key_code_q (key_prev_s)
  );

  // The previous keycode only matters inside the edge detector.
  assign unused_s = ^key_prev_s;

  assign key_off_s  = keycode - KEY_1;
  assign move_key_s = (keycode >= KEY_1) && (keycode < KEY_MOVE_END);
  assign abort_ok_s = abort && (state_r != ST_IDLE) && (state_r != ST_END);

  // Next-state decode; abort overrides whatever the table below chose.
  always_comb begin
    state_fsm_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fight_on) state_fsm_s = ST_DECIDE;
        else          state_fsm_s = ST_IDLE;
      end
      ST_DECIDE: begin
        if (key_new_s && (keycode == KEY_F))
          state_fsm_s = ST_MOVE_SEL;
        else if (key_new_s && (keycode == KEY_E) && (ESCAPE_EN == 1'b1))
          state_fsm_s = ST_ESCAPE;
        else
          state_fsm_s = ST_DECIDE;
      end
      ST_MOVE_SEL: begin
        if (key_new_s && move_key_s)
          state_fsm_s = ST_USER_ATTACK;
        else if (key_new_s && (keycode == KEY_BKSP))
          state_fsm_s = ST_DECIDE;
        else
          state_fsm_s = ST_MOVE_SEL;
      end
      ST_USER_ATTACK: state_fsm_s = ST_USER_HOLD;
      ST_USER_HOLD: begin
        // Faint flags only count on the last hold frame; the user strikes
        // first, so a wild faint wins over a simultaneous user faint.
        if (timer_r == HOLD_LAST)
          state_fsm_s = wild_faint ? ST_WILD_FAINT : ST_WILD_ATTACK;
        else
          state_fsm_s = ST_USER_HOLD;
      end
      ST_WILD_ATTACK: state_fsm_s = ST_WILD_HOLD;
      ST_WILD_HOLD: begin
        if (timer_r == HOLD_LAST)
          state_fsm_s = user_faint ? ST_USER_FAINT : ST_DECIDE;
        else
          state_fsm_s = ST_WILD_HOLD;
      end
      ST_USER_FAINT, ST_WILD_FAINT: begin
        if (timer_r == FAINT_LAST) state_fsm_s = ST_END;
        else                       state_fsm_s = state_r;
      end
      ST_ESCAPE: begin
        if (timer_r == ESC_LAST) state_fsm_s = ST_END;
        else                     state_fsm_s = ST_ESCAPE;
      end
      ST_END:  state_fsm_s = ST_IDLE;
      default: state_fsm_s = ST_IDLE;
    endcase
    state_next_s = abort_ok_s ? ST_END : state_fsm_s;
  end

  // State register plus the Moore outputs, registered from the next state.
  always_ff @(posedge frameClk) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      user_hit     <= 1'b0;
      wild_hit     <= 1'b0;
      battle_end   <= 1'b0;
      busy         <= 1'b0;
      battle_state <= 4'd0;
    end else begin
      state_r      <= state_next_s;
      user_hit     <= (state_next_s == ST_USER_ATTACK);
      wild_hit     <= (state_next_s == ST_WILD_ATTACK);
      battle_end   <= (state_next_s == ST_END);
      busy         <= (state_next_s != ST_IDLE);
      battle_state <= state_next_s;
    end
  end

  // Dwell timer: zero on the first frame of every state, +1 while staying.
  // Timed states leave at LEN-1, so it never wraps where it is looked at.
  always_ff @(posedge frameClk) begin
    if (Reset) begin
      timer_r <= '0;
    end else if (state_next_s != state_r) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TIMER_ONE;
    end
  end

  // Per-battle bookkeeping: turn counter and chosen move.
  always_ff @(posedge frameClk) begin
    if (Reset) begin
      turn_count <= 8'd0;
      move_sel   <= '0;
    end else if ((state_r == ST_IDLE) && fight_on) begin
      turn_count <= 8'd0;
      move_sel   <= '0;
    end else begin
      if ((state_r == ST_WILD_HOLD) && (state_next_s == ST_DECIDE) &&
          (turn_count != 8'd255))
        turn_count <= turn_count + 8'd1;
      else
        turn_count <= turn_count;
      if ((state_r == ST_MOVE_SEL) && (state_next_s == ST_USER_ATTACK))
        move_sel <= key_off_s[MW-1:0];
      else
        move_sel <= move_sel;
    end
  end

endmodule

// File: tb/tb_battle_sequencer.sv
// Self-checking bench for battle_sequencer. Each record holds the inputs for
// a run of frames and the state/pulse counts/counters expected at its end.
module tb_battle_sequencer;
  import battle_pkg::*;

  typedef struct {
    int         n;
    logic       rst;
    logic [7:0] key;
    logic       fight;
    logic       abrt;
    logic       uf;
    logic       wf;
    logic [3:0] st;
    int         uh;
    int         wh;
    int         en;
    logic [7:0] turn;
    logic [2:0] mv;
  } vec_t;

  logic       frameClk = 1'b0;
  logic       Reset = 1'b1;
  logic       hold2 = 1'b1;
  logic       Reset2;
  logic [7:0] keycode = 8'h00;
  logic       fight_on = 1'b0, abort = 1'b0, user_faint = 1'b0, wild_faint = 1'b0;

  logic       user_hit, wild_hit, battle_end, busy;
  logic [2:0] move_sel;
  logic [7:0] turn_count;
  logic [3:0] battle_state;

  logic       user_hit2, wild_hit2, battle_end2, busy2;
  logic [2:0] move_sel2;
  logic [7:0] turn_count2;
  logic [3:0] battle_state2;

  int total = 0;
  int bad   = 0;
  int vec_idx = 0;
  vec_t tbl[$];
  vec_t sb_q[$];

  always #5 frameClk = ~frameClk;
  assign Reset2 = Reset | hold2;

  battle_sequencer dut (
    .frameClk(frameClk), .Reset(Reset), .keycode(keycode), .fight_on(fight_on),
    .abort(abort), .user_faint(user_faint), .wild_faint(wild_faint),
    .user_hit(user_hit), .wild_hit(wild_hit), .move_sel(move_sel),
    .battle_end(battle_end), .busy(busy), .turn_count(turn_count),
    .battle_state(battle_state)
  );

  // Trainer-battle variant: escape key must be ignored.
  battle_sequencer #(.ESCAPE_EN(1'b0)) dut_noesc (
    .frameClk(frameClk), .Reset(Reset2), .keycode(keycode), .fight_on(fight_on),
    .abort(abort), .user_faint(user_faint), .wild_faint(wild_faint),
    .user_hit(user_hit2), .wild_hit(wild_hit2), .move_sel(move_sel2),
    .battle_end(battle_end2), .busy(busy2), .turn_count(turn_count2),
    .battle_state(battle_state2)
  );

  function automatic vec_t mk(input int n, input logic rst, input logic [7:0] key,
                              input logic fight, input logic abrt, input logic uf,
                              input logic wf, input logic [3:0] st, input int uh,
                              input int wh, input int en, input logic [7:0] turn,
                              input logic [2:0] mv);
    vec_t v;
    v.n = n; v.rst = rst; v.key = key; v.fight = fight; v.abrt = abrt;
    v.uf = uf; v.wf = wf; v.st = st; v.uh = uh; v.wh = wh; v.en = en;
    v.turn = turn; v.mv = mv;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, vec_idx, got, want);
    end
  endtask

  // Drive one record for v.n frames, counting pulses, then score it.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int uh = 0, wh = 0, en = 0;
    sb_q.push_back(v);
    for (int i = 0; i < v.n; i++) begin
      Reset = v.rst; keycode = v.key; fight_on = v.fight; abort = v.abrt;
      user_faint = v.uf; wild_faint = v.wf;
      @(posedge frameClk);
      #1;
      if (user_hit === 1'b1)   uh++;
      if (wild_hit === 1'b1)   wh++;
      if (battle_end === 1'b1) en++;
    end
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("battle_state", int'(battle_state), int'(e.st));
      check("busy", int'(busy), (e.st != 4'd0) ? 1 : 0);
      check("user_hit_frames", uh, e.uh);
      check("wild_hit_frames", wh, e.wh);
      check("battle_end_frames", en, e.en);
      check("turn_count", int'(turn_count), int'(e.turn));
      check("move_sel", int'(move_sel), int'(e.mv));
    end
    vec_idx++;
  endtask

  initial begin
    // reset
    tbl.push_back(mk(2,   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0, 8'd0, 3'd0));
    // full turn with move '2'; early wild_faint inside the hold is ignored
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd0, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 0, 0, 0, 8'd0, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(1,   1'b0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(127, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 0, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 0, 1, 0, 8'd0, 3'd1));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 0, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(127, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 0, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd1, 3'd1));
    // held F, out-of-range move key, backspace
    tbl.push_back(mk(10,  1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 0, 0, 0, 8'd1, 3'd1));
    tbl.push_back(mk(3,   1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 0, 0, 0, 8'd1, 3'd1));
    tbl.push_back(mk(2,   1'b0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd1, 3'd1));
    // second turn with F held across it: must not reopen MOVE_SEL in DECIDE
    tbl.push_back(mk(1,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 0, 0, 0, 8'd1, 3'd1));
    tbl.push_back(mk(1,   1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1, 0, 0, 8'd1, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd1, 3'd0));
    tbl.push_back(mk(127, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd1, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 0, 1, 0, 8'd1, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 0, 0, 0, 8'd1, 3'd0));
    tbl.push_back(mk(127, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 0, 0, 0, 8'd1, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd2, 3'd0));
    tbl.push_back(mk(3,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd2, 3'd0));
    // both faint flags at USER_HOLD end -> WILD_FAINT for 256 frames
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd2, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 0, 0, 0, 8'd2, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1, 0, 0, 8'd2, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd2, 3'd0));
    tbl.push_back(mk(127, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd2, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 0, 0, 0, 8'd2, 3'd0));
    tbl.push_back(mk(255, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 0, 0, 0, 8'd2, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 0, 0, 1, 8'd2, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0, 8'd2, 3'd0));
    // new battle clears turn_count; user faints at WILD_HOLD end
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd0, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 0, 0, 0, 8'd0, 3'd0));
    tbl.push_back(mk(1,   1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(127, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 0, 1, 0, 8'd0, 3'd2));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 0, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(127, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 0, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 0, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(255, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 0, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 0, 0, 1, 8'd0, 3'd2));
    tbl.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0, 8'd0, 3'd2));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Escape: 64 frames then END; the trainer variant stays in DECIDE.
    // fight_on left high through END re-enters DECIDE after IDLE.
    hold2 = 1'b0;
    run_vec(mk(1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd0, 3'd0));
    check("noesc_start_state", int'(battle_state2), 1);
    run_vec(mk(1,  1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 0, 0, 0, 8'd0, 3'd0));
    check("noesc_after_E_state", int'(battle_state2), 1);
    run_vec(mk(63, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 0, 0, 0, 8'd0, 3'd0));
    run_vec(mk(1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 0, 0, 1, 8'd0, 3'd0));
    run_vec(mk(1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0, 8'd0, 3'd0));
    run_vec(mk(1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd0, 3'd0));
    check("noesc_end_state", int'(battle_state2), 1);
    check("noesc_end_pulse", int'(battle_end2), 0);

    // Abort in the middle of USER_HOLD: END next frame, never a wild_hit;
    // abort is ignored in END and IDLE.
    run_vec(mk(1,  1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 0, 0, 0, 8'd0, 3'd0));
    run_vec(mk(1,  1'b0, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1, 0, 0, 8'd0, 3'd3));
    run_vec(mk(1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd0, 3'd3));
    run_vec(mk(50, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd0, 3'd3));
    run_vec(mk(1,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd10, 0, 0, 1, 8'd0, 3'd3));
    run_vec(mk(1,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 0, 0, 0, 8'd0, 3'd3));
    run_vec(mk(2,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 0, 0, 0, 8'd0, 3'd3));

    // Reset during WILD_FAINT: straight to IDLE, everything cleared, no end pulse.
    run_vec(mk(1,   1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 8'd0, 3'd0));
    run_vec(mk(1,   1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 0, 0, 0, 8'd0, 3'd0));
    run_vec(mk(1,   1'b0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1, 0, 0, 8'd0, 3'd1));
    run_vec(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd0, 3'd1));
    run_vec(mk(127, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, 0, 8'd0, 3'd1));
    run_vec(mk(1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 0, 0, 0, 8'd0, 3'd1));
    run_vec(mk(10,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 0, 0, 0, 8'd0, 3'd1));
    run_vec(mk(1,   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 0, 0, 0, 8'd0, 3'd0));
    check("reset_user_hit", int'(user_hit), 0);
    check("reset_wild_hit", int'(wild_hit), 0);
    run_vec(mk(3,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0, 8'd0, 3'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
